// File: rtl/pipe_stage_buf_pkg.sv
// Shared types for the inter-stage pipeline buffer.
//   ExceptPack    : exception sideband travelling with each pipeline entry
//   EXCEPT_NONE   : sideband value for "no exception" (reset value)
//   occ_e         : occupancy encoding reported by the buffer
//   ExeMemPayload : example packed stage payload (EXE/MEM) and its width
package pipe_stage_buf_pkg;

   typedef struct packed {
      logic        except;
      logic [31:0] epc;
      logic [4:0]  ecause;
      logic [31:0] etval;
   } ExceptPack;

   localparam ExceptPack EXCEPT_NONE = '{except: 1'b0, epc: 32'd0, ecause: 5'd0, etval: 32'd0};

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [63:0] alu_result;
      logic [63:0] store_data;
      logic [63:0] csr_wdata;
   } ExeMemPayload;

   localparam int EXE_MEM_W = $bits(ExeMemPayload);

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage slot of the pipeline buffer: a {valid, data, exception} register.
//   clk, rst (async, active-low)
//   load       : capture load_data/load_exc and mark the slot valid
//   clear      : mark the slot empty (payload is left untouched); wins over load
//   load_data  : payload to capture
//   load_exc   : exception sideband to capture
//   valid/data/exc : current slot contents
module pipe_entry_reg
   import pipe_stage_buf_pkg::*;
#(
   parameter int DATA_W = EXE_MEM_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] load_data,
   input  ExceptPack         load_exc,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output ExceptPack         exc
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         data  <= '0;
         exc   <= EXCEPT_NONE;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         exc   <= load_exc;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional
// 2-entry skid buffer, flush and an exception fence.
//   clk, rst (async, active-low), flush (sync kill of all held entries)
//   in_valid / in_ready / in_data / in_except     : upstream side
//   out_valid / out_ready / out_data / out_except : downstream side (head entry)
//   occupancy : number of entries held (0, 1, 2)
// SKID_EN=1 gives a registered in_ready (no combinational path from out_ready);
// SKID_EN=0 uses a single slot with in_ready depending on out_ready.
// EXC_FENCE=1 stops intake behind an excepting entry until it leaves.
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int DATA_W    = EXE_MEM_W,
   parameter bit SKID_EN   = 1'b1,
   parameter bit EXC_FENCE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  ExceptPack         in_except,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output ExceptPack         out_except,
   output logic [1:0]        occupancy
);

   logic              main_v;
   logic              skid_v;
   logic [DATA_W-1:0] skid_data;
   ExceptPack         skid_exc;
   logic              fence;
   logic              in_fire;
   logic              out_fire;
   logic              main_load_in;
   logic              main_load_skid;
   logic              main_load;
   logic              main_clear;
   logic              skid_load;
   logic              skid_clear;
   logic [DATA_W-1:0] main_next_data;
   ExceptPack         main_next_exc;
   occ_e              occ;

   assign out_valid = main_v;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_v & out_ready;

   generate
      if (SKID_EN) begin : g_ready_reg
         // Only registered terms: the skid slot absorbs the cycle of latency.
         assign in_ready = rst & ~skid_v & ~fence;
      end else begin : g_ready_comb
         assign in_ready = rst & ~fence & (~main_v | out_ready);
      end
   endgenerate

   // Main refills from the skid slot when it holds something, otherwise
   // from the input when main is (or is becoming) free.
   assign main_load_in   = in_fire & (~main_v | out_fire);
   assign main_load_skid = out_fire & skid_v;
   assign main_load      = ~flush & (main_load_in | main_load_skid);
   assign main_clear     = flush | (out_fire & ~main_load_in & ~main_load_skid);
   assign main_next_data = main_load_skid ? skid_data : in_data;
   assign main_next_exc  = main_load_skid ? skid_exc : in_except;

   // Overflow goes to skid only when main stays occupied this edge.
   assign skid_load  = ~flush & in_fire & main_v & ~out_fire;
   assign skid_clear = flush | main_load_skid;

   pipe_entry_reg #(.DATA_W(DATA_W)) u_main (
      .clk       (clk),
      .rst       (rst),
      .load      (main_load),
      .clear     (main_clear),
      .load_data (main_next_data),
      .load_exc  (main_next_exc),
      .valid     (main_v),
      .data      (out_data),
      .exc       (out_except)
   );

   generate
      if (SKID_EN) begin : g_skid
         pipe_entry_reg #(.DATA_W(DATA_W)) u_skid (
            .clk       (clk),
            .rst       (rst),
            .load      (skid_load),
            .clear     (skid_clear),
            .load_data (in_data),
            .load_exc  (in_except),
            .valid     (skid_v),
            .data      (skid_data),
            .exc       (skid_exc)
         );
      end else begin : g_no_skid
         assign skid_v    = 1'b0;
         assign skid_data = '0;
         assign skid_exc  = EXCEPT_NONE;
      end
   endgenerate

   // The fence blocks intake, so the excepting entry is always the youngest
   // held entry; the next out_fire of an excepting head is therefore that entry.
   generate
      if (EXC_FENCE) begin : g_fence
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               fence <= 1'b0;
            end else if (flush) begin
               fence <= 1'b0;
            end else if (in_fire & in_except.except) begin
               fence <= 1'b1;
            end else if (out_fire & out_except.except) begin
               fence <= 1'b0;
            end
         end
      end else begin : g_no_fence
         assign fence = 1'b0;
      end
   endgenerate

   always_comb begin
      occ = OCC_EMPTY;
      if (skid_v) begin
         occ = OCC_TWO;
      end else if (main_v) begin
         occ = OCC_ONE;
      end
   end

   assign occupancy = occ;

endmodule
